// File: rtl/demux_1_to_2_reg_pkg.sv
// demux_1_to_2_reg_pkg
// Shared definitions for the registered 1-to-2 demultiplexer:
//   LANE0 / LANE1    lane index values carried on the select bit
//   DEFAULT_WIDTH    processor datapath width
//   lane_state_e     per-lane holding register occupancy
//   lane_can_load()  whether a lane can take a new word this cycle
package demux_1_to_2_reg_pkg;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  // A lane can be refilled when it is empty, or when its current word is
  // leaving on the same edge (drain and fill together).
  function automatic logic lane_can_load(input lane_state_e st, input logic ready);
    return (st == LANE_EMPTY) | ready;
  endfunction

endpackage

// File: rtl/demux_1_to_2_reg_if.sv
// demux_1_to_2_reg_if
// Producer stream plus the two consumer lanes of the demultiplexer.
//   a1, s1, in_valid / in_ready      producer word, lane select, handshake
//   o0, o0_valid / o0_ready          lane 0 word and handshake
//   o1, o1_valid / o1_ready          lane 1 word and handshake
//   cnt0, cnt1                       accepted-word counters per lane
// Modports: slave = the demux, master = the environment driving it.
interface demux_1_to_2_reg_if
  import demux_1_to_2_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0] a1;
  logic             s1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o0;
  logic             o0_valid;
  logic             o0_ready;
  logic [WIDTH-1:0] o1;
  logic             o1_valid;
  logic             o1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  a1, s1, in_valid, o0_ready, o1_ready,
    output in_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1
  );

  modport master (
    output a1, s1, in_valid, o0_ready, o1_ready,
    input  in_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1
  );

endinterface

// File: rtl/demux_1_to_2_reg_lane.sv
// demux_lane_reg
// One-entry holding register for a single demux lane, with an accepted-word
// counter.
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        a word is being accepted into this lane this edge
//   i_data        word to load
//   i_ready       lane consumer takes the held word
//   o_data        held word (last loaded value, also while empty)
//   o_valid       lane holds a word
//   o_cnt         words accepted into this lane, wraps silently
//   o_can_load    lane can accept a word this cycle
module demux_lane_reg
  import demux_1_to_2_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_can_load
);

  lane_state_e      r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LANE_EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      // A load wins over a drain on the same edge, so the lane stays full
      // with the new word and sustains one word per cycle.
      if (i_load) begin
        r_state <= LANE_FULL;
        r_data  <= i_data;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if ((r_state == LANE_FULL) && i_ready) begin
        r_state <= LANE_EMPTY;
      end
    end
  end

  assign o_data     = r_data;
  assign o_valid    = (r_state == LANE_FULL);
  assign o_cnt      = r_cnt;
  assign o_can_load = lane_can_load(r_state, i_ready);

endmodule

// File: rtl/demux_1_to_2_reg.sv
// demux_1_to_2_reg
// Registered 1-to-2 demultiplexer: each producer word is steered by s1 into
// one of two one-entry lane registers, so a stalled lane does not block
// traffic bound for the other lane.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (clears lanes, data and counters)
//   bus     demux_1_to_2_reg_if.slave: producer stream, two lanes, counters
module demux_1_to_2_reg
  import demux_1_to_2_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1_to_2_reg_if.slave    bus
);

  logic w_can_load0;
  logic w_can_load1;
  logic w_in_ready;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Ready depends only on the addressed lane, never on in_valid, and is
  // forced low while reset is asserted.
  assign w_in_ready = rst_n & ((bus.s1 == LANE1) ? w_can_load1 : w_can_load0);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_load0    = w_accept & (bus.s1 == LANE0);
  assign w_load1    = w_accept & (bus.s1 == LANE1);

  assign bus.in_ready = w_in_ready;

  demux_lane_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lane0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load0),
    .i_data     (bus.a1),
    .i_ready    (bus.o0_ready),
    .o_data     (bus.o0),
    .o_valid    (bus.o0_valid),
    .o_cnt      (bus.cnt0),
    .o_can_load (w_can_load0)
  );

  demux_lane_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lane1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load1),
    .i_data     (bus.a1),
    .i_ready    (bus.o1_ready),
    .o_data     (bus.o1),
    .o_valid    (bus.o1_valid),
    .o_cnt      (bus.cnt1),
    .o_can_load (w_can_load1)
  );

endmodule

// File: tb/tb_demux_1_to_2_reg.sv
// tb_demux_1_to_2_reg
// Directed bench for demux_1_to_2_reg: a table of per-cycle vectors for the
// routing, stall and drain/fill cases, plus hand-written sequences for reset,
// back-to-back streaming, mid-operation reset and counter wrap (CNT_W=4).
module tb_demux_1_to_2_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  demux_1_to_2_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux_1_to_2_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic        s1;
    logic [31:0] a1;
    logic        o0_ready;
    logic        o1_ready;
    logic        exp_in_ready;
    logic        exp_o0_valid;
    logic [31:0] exp_o0;
    logic        exp_o1_valid;
    logic [31:0] exp_o1;
    logic [3:0]  exp_cnt0;
    logic [3:0]  exp_cnt1;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // in_valid, s1, a1, o0_ready, o1_ready | in_ready, o0_valid, o0, o1_valid, o1, cnt0, cnt1
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 32'h0,          4'd1, 4'd0};
    vecs[1] = '{1'b1, 1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'hCAFE_0001, 4'd1, 4'd1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_000A, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_000A, 1'b0, 32'hCAFE_0001, 4'd2, 4'd1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_000B, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000A, 1'b0, 32'hCAFE_0001, 4'd2, 4'd1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_000A, 1'b1, 32'h0000_000C, 4'd2, 4'd2};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_000A, 1'b0, 32'h0000_000C, 4'd2, 4'd2};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 32'h0000_000C, 4'd3, 4'd2};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0022, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 32'h0000_000C, 4'd4, 4'd2};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0022, 1'b0, 32'h0000_000C, 4'd4, 4'd2};

    // Reset held with a word offered: nothing may be accepted.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a1       = 32'hDEAD_BEEF;
    bus.s1       = 1'b0;
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_o0_valid", 32'(bus.o0_valid), 32'd0);
    chk("rst_o1_valid", 32'(bus.o1_valid), 32'd0);
    chk("rst_o0", bus.o0, 32'd0);
    chk("rst_o1", bus.o1, 32'd0);
    chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
    chk("rst_cnt1", 32'(bus.cnt1), 32'd0);

    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready_s0", 32'(bus.in_ready), 32'd1);
    bus.s1 = 1'b1;
    #1;
    chk("rel_in_ready_s1", 32'(bus.in_ready), 32'd1);

    // Table: routing, stall isolation, drain/fill on one lane.
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = vecs[i].in_valid;
      bus.s1       = vecs[i].s1;
      bus.a1       = vecs[i].a1;
      bus.o0_ready = vecs[i].o0_ready;
      bus.o1_ready = vecs[i].o1_ready;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_o0_valid", i), 32'(bus.o0_valid), 32'(vecs[i].exp_o0_valid));
      chk($sformatf("v%0d_o0", i), bus.o0, vecs[i].exp_o0);
      chk($sformatf("v%0d_o1_valid", i), 32'(bus.o1_valid), 32'(vecs[i].exp_o1_valid));
      chk($sformatf("v%0d_o1", i), bus.o1, vecs[i].exp_o1);
      chk($sformatf("v%0d_cnt0", i), 32'(bus.cnt0), 32'(vecs[i].exp_cnt0));
      chk($sformatf("v%0d_cnt1", i), 32'(bus.cnt1), 32'(vecs[i].exp_cnt1));
    end
    bus.in_valid = 1'b0;

    // Back-to-back: eight words into lane 1 with its consumer always ready.
    do_reset();
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.s1       = 1'b1;
      bus.a1       = 32'(i);
      #1;
      chk($sformatf("b2b%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_o1", i), bus.o1, 32'(i));
      chk($sformatf("b2b%0d_o1_valid", i), 32'(bus.o1_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    chk("b2b_cnt1", 32'(bus.cnt1), 32'd8);
    chk("b2b_cnt0", 32'(bus.cnt0), 32'd0);

    // Mid-operation reset with both lanes full.
    do_reset();
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.s1       = 1'b0;
    bus.a1       = 32'h55;
    @(posedge clk);
    #1;
    bus.s1 = 1'b1;
    bus.a1 = 32'h66;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("mid_full_o0_valid", 32'(bus.o0_valid), 32'd1);
    chk("mid_full_o1_valid", 32'(bus.o1_valid), 32'd1);
    chk("mid_full_o1", bus.o1, 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o0_valid", 32'(bus.o0_valid), 32'd0);
    chk("mid_rst_o1_valid", 32'(bus.o1_valid), 32'd0);
    chk("mid_rst_o0", bus.o0, 32'd0);
    chk("mid_rst_o1", bus.o1, 32'd0);
    chk("mid_rst_cnt0", 32'(bus.cnt0), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter wrap: 17 words into lane 0 with a 4-bit counter.
    bus.o0_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = 1'b1;
      bus.s1       = 1'b0;
      bus.a1       = 32'(i + 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("wrap_cnt0", 32'(bus.cnt0), 32'd1);
    chk("wrap_o0", bus.o0, 32'd17);
    chk("wrap_cnt1", 32'(bus.cnt1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
